// File: rtl/alu_issue.sv
// ALU issue stage: register file x0..x31 plus a single-entry operand register feeding the ALU.
// Same-cycle writeback forwarding into operand read is selected by BYPASS.
module alu_issue #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  input  logic        in_use_imm,
  input  logic [3:0]  in_control,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_control,
  output logic [31:0] out_input1,
  output logic [31:0] out_input2,
  output logic [4:0]  out_rd,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              accept;
  logic [XLEN-1:0]   regs [NREG];
  logic [XLEN-1:0]   op1, op2;
  logic              wb_live;

  assign out_valid = (state_q == FULL);
  assign in_ready  = (state_q == EMPTY) || out_ready;
  assign wb_live   = wb_en && (wb_rd != 5'd0);

  // Next-state: a simultaneous accept and consume keeps the stage full.
  always_comb begin
    state_d = state_q;
    accept  = in_valid && in_ready;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Operand read with optional forwarding of the writeback landing on this edge.
  always_comb begin
    op1 = regs[in_rs1];
    op2 = in_use_imm ? in_imm : regs[in_rs2];
    if (BYPASS && wb_live) begin
      if (wb_rd == in_rs1)                 op1 = wb_data;
      if (!in_use_imm && (wb_rd == in_rs2)) op2 = wb_data;
    end
    if (in_rs1 == 5'd0)                 op1 = '0;
    if (!in_use_imm && (in_rs2 == 5'd0)) op2 = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_control <= '0;
      out_input1  <= '0;
      out_input2  <= '0;
      out_rd      <= '0;
    end else if (accept) begin
      out_control <= in_control;
      out_input1  <= op1;
      out_input2  <= op2;
      out_rd      <= in_rd;
    end
  end

  // Register file; entry 0 is never written and therefore reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (wb_live) begin
      regs[wb_rd] <= wb_data;
    end
  end

endmodule
